// File: rtl/multiword_add_sequencer_if.sv
// rtl/multiword_add_sequencer_if.sv - operand/result handshake bundle for the word-serial adder
interface multiword_add_sequencer_if #(
    parameter int WIDTH  = 8,
    parameter int CHUNKS = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH*CHUNKS-1:0]   a;
    logic [WIDTH*CHUNKS-1:0]   b;
    logic                      cin;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH*CHUNKS-1:0]   sum;
    logic                      cout;
    logic                      ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/multiword_add_sequencer.sv
// rtl/multiword_add_sequencer.sv - wide adder built from one WIDTH-bit slice, one chunk per clock
module multiword_add_sequencer #(
    parameter int WIDTH  = 8,
    parameter int CHUNKS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    multiword_add_sequencer_if.slave   bus,
    output logic                       busy
);
    localparam int TOTAL = WIDTH * CHUNKS;
    localparam int CW    = (CHUNKS < 2) ? 1 : $clog2(CHUNKS + 1);
    localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [TOTAL-1:0]  a_q, a_d;
    logic [TOTAL-1:0]  b_q, b_d;
    logic [TOTAL-1:0]  acc_q, acc_d;
    logic [TOTAL-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [WIDTH:0]    slice_c;
    logic [WIDTH-1:0]  slice_s;

    // The single shared ripple slice; slice_c[WIDTH-1] is the carry into the chunk MSB.
    always_comb begin
        slice_c    = '0;
        slice_s    = '0;
        slice_c[0] = carry_q;
        for (int i = 0; i < WIDTH; i++) begin
            slice_s[i]   = a_q[i] ^ b_q[i] ^ slice_c[i];
            slice_c[i+1] = (a_q[i] & b_q[i]) | (slice_c[i] & (a_q[i] ^ b_q[i]));
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d   = a_q >> WIDTH;
                b_d   = b_q >> WIDTH;
                acc_d = acc_q >> WIDTH;
                acc_d[TOTAL-1 -: WIDTH] = slice_s;
                carry_d = slice_c[WIDTH];
                cnt_d   = cnt_q + CW'(1);
                // Result is published only on the last chunk so sum stays stable outside DONE.
                if (cnt_q == LAST) begin
                    sum_d   = acc_d;
                    cout_d  = slice_c[WIDTH];
                    ovf_d   = slice_c[WIDTH-1] ^ slice_c[WIDTH];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign busy          = (state_q != S_IDLE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb/tb_multiword_add_sequencer.sv - scoreboard bench for the word-serial adder
module tb_multiword_add_sequencer;
    localparam int WIDTH  = 8;
    localparam int CHUNKS = 4;

    logic clk;
    logic rst_n;
    logic busy;
    int   checks;
    int   failures;
    int   cycle;
    int   last_accept;

    logic [33:0] exp_q[$];

    multiword_add_sequencer_if #(.WIDTH(WIDTH), .CHUNKS(CHUNKS)) bus ();

    multiword_add_sequencer #(.WIDTH(WIDTH), .CHUNKS(CHUNKS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every completed output handshake is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 64'(1), 64'(0));
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                chk("result_sum",  64'(bus.sum),  64'(e[33:2]));
                chk("result_cout", 64'(bus.cout), 64'(e[1]));
                chk("result_ovf",  64'(bus.ovf),  64'(e[0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic ci,
                        input logic [31:0] es, input logic ec, input logic eo,
                        input int exp_gap);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("in_ready_wait", 64'(bus.in_ready), 64'(1));
        bus.a        = av;
        bus.b        = bv;
        bus.cin      = ci;
        bus.in_valid = 1'b1;
        exp_q.push_back({es, ec, eo});
        tick();
        if (exp_gap > 0) chk("accept_spacing", 64'(cycle - last_accept), 64'(exp_gap));
        last_accept  = cycle;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        chk("latency", 64'(n), 64'(CHUNKS));
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        cycle         = 0;
        last_accept   = 0;
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;

        #2 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready",  64'(bus.in_ready),  64'(1));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_sum",       64'(bus.sum),       64'(0));
        chk("rst_cout",      64'(bus.cout),      64'(0));
        chk("rst_busy",      64'(busy),          64'(0));

        send(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 0);
        send(32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 0);
        send(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 0);

        // Backpressure: result must hold and new operands must be refused while DONE stalls.
        tick();
        bus.out_ready = 1'b0;
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 0);
        bus.a        = 32'h00000005;
        bus.b        = 32'h00000006;
        bus.cin      = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_out_valid", 64'(bus.out_valid), 64'(1));
            chk("bp_in_ready",  64'(bus.in_ready),  64'(0));
            chk("bp_sum",       64'(bus.sum),       64'hFFFFFFFF);
            chk("bp_cout",      64'(bus.cout),      64'(1));
        end
        bus.out_ready = 1'b1;
        tick();
        chk("release_in_ready",  64'(bus.in_ready),  64'(1));
        chk("release_out_valid", 64'(bus.out_valid), 64'(0));
        chk("release_busy",      64'(busy),          64'(0));
        chk("release_sum_held",  64'(bus.sum),       64'hFFFFFFFF);
        exp_q.push_back({32'h0000000B, 1'b0, 1'b0});
        tick();
        chk("second_taken_busy", 64'(busy),         64'(1));
        chk("second_in_ready",   64'(bus.in_ready), 64'(0));
        bus.in_valid = 1'b0;
        for (int n = 0; n < 50 && !bus.out_valid; n++) tick();
        chk("second_done", 64'(bus.out_valid), 64'(1));
        tick();

        // Reset after two RUN edges must discard the in-flight add.
        bus.a        = 32'h00FF00FF;
        bus.b        = 32'h00010001;
        bus.cin      = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready",  64'(bus.in_ready),  64'(1));
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("mid_rst_busy",      64'(busy),          64'(0));
        chk("mid_rst_sum",       64'(bus.sum),       64'(0));
        chk("mid_rst_cout",      64'(bus.cout),      64'(0));
        chk("mid_rst_ovf",       64'(bus.ovf),       64'(0));
        tick();
        rst_n = 1'b1;
        tick();
        send(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0, 0);

        send(32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0, 1'b0, 0);
        send(32'h000000FF, 32'h00000000, 1'b1, 32'h00000100, 1'b0, 1'b0, CHUNKS + 2);
        send(32'h40000000, 32'h40000000, 1'b0, 32'h80000000, 1'b0, 1'b1, CHUNKS + 2);

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
